// File: rtl/pc_branch_unit_if.sv
// Fetch-control bundle between decode and pc_branch_unit: the master drives control, the slave returns PC state.
// Carries no storage of its own. Stall is level-based: while it is high the unit holds all of its state.
interface pc_branch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int IM_W   = 15
);
   logic              stall;
   logic [1:0]        pc_sel;
   logic              br_cond;
   logic [IM_W-1:0]   imm;
   logic [ADDR_W-1:0] jr_addr;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_2;
   logic [ADDR_W-1:0] bra;
   logic              redirect;
   logic              flush;
   logic              bra_ovf;

   modport master (
      output stall, pc_sel, br_cond, imm, jr_addr,
      input  pc, pc_2, bra, redirect, flush, bra_ovf
   );

   modport slave (
      input  stall, pc_sel, br_cond, imm, jr_addr,
      output pc, pc_2, bra, redirect, flush, bra_ovf
   );
endinterface

// File: rtl/pc_branch_unit.sv
// PC register, pipelined pc+1, branch target and wrong-path squash; PC_BRANCH_OVF_EN adds a registered branch-wrap flag.
// Next PC appears 1 clock after pc_sel/imm, and the first correct-path decode follows FLUSH_CYCLES+1 clocks after a redirect. A stall freezes every register.
module pc_branch_unit #(
   parameter int                ADDR_W       = 32,
   parameter int                IM_W         = 15,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0,
   parameter int                FLUSH_CYCLES = 1
) (
   input logic             clk,
   input logic             rst_n,
   pc_branch_unit_if.slave bus
);

   typedef enum logic [0:0] {RUN, FLUSH} state_t;

   state_t            state;
   logic [1:0]        flushCnt;
   logic              flushQ;
   logic [ADDR_W-1:0] pcQ;
   logic [ADDR_W-1:0] pc2Q;
   logic [ADDR_W-1:0] pcInc;
   logic [ADDR_W-1:0] immSext;
   logic [ADDR_W-1:0] braSum;
   logic [ADDR_W-1:0] nextPc;
   logic              takeJump;
   logic              takeBranch;
   logic              redirect;

   assign pcInc   = pcQ + 1'b1;
   assign immSext = {{(ADDR_W-IM_W){bus.imm[IM_W-1]}}, bus.imm};

`ifdef PC_BRANCH_OVF_EN
   logic [ADDR_W:0] braWide;
   logic            carryOut;
   logic            wrapWrong;
   logic            braOvfQ;

   assign braWide  = {1'b0, pc2Q} + {1'b0, immSext};
   assign braSum   = braWide[ADDR_W-1:0];
   assign carryOut = braWide[ADDR_W];
   // A forward offset must not carry; a backward offset must carry.
   assign wrapWrong = immSext[ADDR_W-1] ? ~carryOut : carryOut;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         braOvfQ <= 1'b0;
      end else if (!bus.stall) begin
         braOvfQ <= takeBranch && redirect && wrapWrong;
      end
   end

   assign bus.bra_ovf = braOvfQ;
`else
   assign braSum      = pc2Q + immSext;
   assign bus.bra_ovf = 1'b0;
`endif

   assign takeJump   = (bus.pc_sel == 2'b10);
   assign takeBranch = (bus.pc_sel == 2'b01) && bus.br_cond;
   // During FLUSH the requester is being squashed, so its pc_sel is not honoured.
   assign redirect   = (state == RUN) && !bus.stall && (takeJump || takeBranch);

   always_comb begin
      nextPc = pcInc;
      if (state == RUN) begin
         if (takeJump) begin
            nextPc = bus.jr_addr;
         end else if (takeBranch) begin
            nextPc = braSum;
         end else if (bus.pc_sel == 2'b11) begin
            nextPc = pcQ;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         flushCnt <= 2'd0;
         flushQ   <= 1'b0;
         pcQ      <= RESET_PC;
         pc2Q     <= '0;
      end else if (!bus.stall) begin
         pc2Q <= pcInc;
         pcQ  <= nextPc;
         case (state)
            RUN: begin
               if (redirect) begin
                  state    <= FLUSH;
                  flushCnt <= 2'(FLUSH_CYCLES - 1);
                  flushQ   <= 1'b1;
               end
            end
            FLUSH: begin
               if (flushCnt == 2'd0) begin
                  state  <= RUN;
                  flushQ <= 1'b0;
               end else begin
                  flushCnt <= flushCnt - 2'd1;
               end
            end
            default: begin
               state  <= RUN;
               flushQ <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc       = pcQ;
   assign bus.pc_2     = pc2Q;
   assign bus.bra      = braSum;
   assign bus.redirect = redirect;
   assign bus.flush    = flushQ;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: u1 runs with FLUSH_CYCLES=1, and u3 runs with FLUSH_CYCLES=3 for the flush-window case.
module tb_pc_branch_unit;

   logic clk = 1'b0;
   logic rst_n;
   int   nAsserts = 0;
   int   nFails   = 0;

`ifdef PC_BRANCH_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   pc_branch_unit_if #(.ADDR_W(32), .IM_W(15)) if1 ();
   pc_branch_unit_if #(.ADDR_W(32), .IM_W(15)) if3 ();

   pc_branch_unit #(.ADDR_W(32), .IM_W(15), .RESET_PC(32'h0), .FLUSH_CYCLES(1)) u1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   pc_branch_unit #(.ADDR_W(32), .IM_W(15), .RESET_PC(32'h0), .FLUSH_CYCLES(3)) u3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      if1.stall   = 1'b0;
      if1.pc_sel  = 2'b00;
      if1.br_cond = 1'b0;
      if1.imm     = 15'h0000;
      if1.jr_addr = 32'h0;
      if3.stall   = 1'b1;
      if3.pc_sel  = 2'b00;
      if3.br_cond = 1'b0;
      if3.imm     = 15'h0000;
      if3.jr_addr = 32'h0;

      // Reset state
      step();
      step();
      chk("rst_pc", if1.pc, 32'h0);
      chk("rst_pc2", if1.pc_2, 32'h0);
      chk("rst_flush", {31'b0, if1.flush}, 32'h0);
      chk("rst_ovf", {31'b0, if1.bra_ovf}, 32'h0);
      chk("rst_bra0", if1.bra, 32'h0);
      if1.imm = 15'h7FFF;
      #1;
      chk("rst_bra_sext", if1.bra, 32'hFFFF_FFFF);
      if1.imm = 15'h0000;
      rst_n   = 1'b1;

      // Sequential fetch after reset release
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("seq_pc", if1.pc, 32'(i));
         chk("seq_pc2", if1.pc_2, 32'(i));
      end

      // Asynchronous reset in mid-cycle
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_pc", if1.pc, 32'h0);
      chk("arst_pc2", if1.pc_2, 32'h0);
      chk("arst_flush", {31'b0, if1.flush}, 32'h0);
      rst_n = 1'b1;

      // Backward branch from pc_2=12 with imm=-12
      for (int i = 0; i < 12; i++) step();
      chk("pre_br_pc", if1.pc, 32'd12);
      chk("pre_br_pc2", if1.pc_2, 32'd12);
      if1.pc_sel  = 2'b01;
      if1.br_cond = 1'b1;
      if1.imm     = 15'h7FF4;
      #1;
      chk("bwd_bra", if1.bra, 32'h0);
      chk("bwd_redirect", {31'b0, if1.redirect}, 32'h1);
      step();
      chk("bwd_pc", if1.pc, 32'h0);
      chk("bwd_pc2", if1.pc_2, 32'd13);
      chk("bwd_flush", {31'b0, if1.flush}, 32'h1);
      chk("bwd_no_ovf", {31'b0, if1.bra_ovf}, 32'h0);
      chk("bwd_squash_redirect", {31'b0, if1.redirect}, 32'h0);
      if1.pc_sel  = 2'b00;
      if1.br_cond = 1'b0;
      step();
      chk("bwd_pc1", if1.pc, 32'h1);
      chk("bwd_flush_end", {31'b0, if1.flush}, 32'h0);
      step();
      chk("bwd_pc2seq", if1.pc, 32'h2);

      // Branch not taken
      if1.pc_sel = 2'b01;
      if1.imm    = 15'h0005;
      #1;
      chk("nt_redirect", {31'b0, if1.redirect}, 32'h0);
      step();
      chk("nt_pc", if1.pc, 32'h3);
      chk("nt_flush", {31'b0, if1.flush}, 32'h0);

      // Jump register; br_cond=1 is ignored
      if1.pc_sel  = 2'b10;
      if1.br_cond = 1'b1;
      if1.jr_addr = 32'h0000_0100;
      #1;
      chk("jr_redirect", {31'b0, if1.redirect}, 32'h1);
      step();
      chk("jr_pc", if1.pc, 32'h100);
      chk("jr_pc2", if1.pc_2, 32'h4);
      chk("jr_flush", {31'b0, if1.flush}, 32'h1);
      if1.pc_sel  = 2'b00;
      if1.br_cond = 1'b0;
      step();
      chk("jr_pc_next", if1.pc, 32'h101);
      chk("jr_flush_end", {31'b0, if1.flush}, 32'h0);

      // Stall in RUN holds the branch request until released
      if1.pc_sel  = 2'b01;
      if1.br_cond = 1'b1;
      if1.imm     = 15'h0010;
      if1.stall   = 1'b1;
      #1;
      chk("st_redirect", {31'b0, if1.redirect}, 32'h0);
      chk("st_bra", if1.bra, 32'h111);
      step();
      chk("st_pc", if1.pc, 32'h101);
      chk("st_pc2", if1.pc_2, 32'h101);
      chk("st_flush", {31'b0, if1.flush}, 32'h0);
      if1.stall = 1'b0;
      #1;
      chk("st_rel_redirect", {31'b0, if1.redirect}, 32'h1);
      step();
      chk("st_rel_pc", if1.pc, 32'h111);
      chk("st_rel_flush", {31'b0, if1.flush}, 32'h1);
      if1.pc_sel  = 2'b00;
      if1.br_cond = 1'b0;
      step();

      // Hold PC
      if1.pc_sel = 2'b11;
      step();
      chk("hold_pc", if1.pc, 32'h112);
      chk("hold_pc2", if1.pc_2, 32'h113);

      // Forward branch wrapping past all-ones
      if1.pc_sel  = 2'b10;
      if1.jr_addr = 32'hFFFF_FFFD;
      step();
      if1.pc_sel = 2'b00;
      step();
      chk("wrap_pc2_setup", if1.pc_2, 32'hFFFF_FFFE);
      if1.pc_sel  = 2'b01;
      if1.br_cond = 1'b1;
      if1.imm     = 15'h0003;
      #1;
      chk("wrap_bra", if1.bra, 32'h1);
      step();
      chk("wrap_pc", if1.pc, 32'h1);
      chk("wrap_ovf", {31'b0, if1.bra_ovf}, {31'b0, OVF_ON});
      if1.pc_sel  = 2'b00;
      if1.br_cond = 1'b0;
      step();
      chk("wrap_ovf_pulse", {31'b0, if1.bra_ovf}, 32'h0);

      // pc+1 from all-ones wraps to zero
      if1.pc_sel  = 2'b10;
      if1.jr_addr = 32'hFFFF_FFFF;
      step();
      chk("ones_pc", if1.pc, 32'hFFFF_FFFF);
      if1.pc_sel = 2'b00;
      step();
      chk("ones_wrap_pc", if1.pc, 32'h0);
      chk("ones_wrap_pc2", if1.pc_2, 32'h0);

      // Backward branch wrapping below zero
      if1.pc_sel  = 2'b01;
      if1.br_cond = 1'b1;
      if1.imm     = 15'h7FFF;
      #1;
      chk("under_bra", if1.bra, 32'hFFFF_FFFF);
      step();
      chk("under_pc", if1.pc, 32'hFFFF_FFFF);
      chk("under_ovf", {31'b0, if1.bra_ovf}, {31'b0, OVF_ON});
      if1.pc_sel  = 2'b00;
      if1.br_cond = 1'b0;

      // FLUSH_CYCLES=3 window with a jump presented mid-flush and a 2-cycle stall
      if3.stall   = 1'b0;
      if3.pc_sel  = 2'b01;
      if3.br_cond = 1'b1;
      if3.imm     = 15'h0020;
      #1;
      chk("f3_bra", if3.bra, 32'h20);
      chk("f3_redirect", {31'b0, if3.redirect}, 32'h1);
      step();
      chk("f3_pc_t0", if3.pc, 32'h20);
      chk("f3_flush_t0", {31'b0, if3.flush}, 32'h1);
      if3.pc_sel  = 2'b10;
      if3.br_cond = 1'b0;
      if3.jr_addr = 32'h0000_0500;
      #1;
      chk("f3_jr_ignored", {31'b0, if3.redirect}, 32'h0);
      step();
      chk("f3_pc_t1", if3.pc, 32'h21);
      chk("f3_flush_t1", {31'b0, if3.flush}, 32'h1);
      if3.stall = 1'b1;
      step();
      step();
      chk("f3_stall_pc", if3.pc, 32'h21);
      chk("f3_stall_pc2", if3.pc_2, 32'h21);
      chk("f3_stall_flush", {31'b0, if3.flush}, 32'h1);
      if3.stall = 1'b0;
      step();
      chk("f3_pc_t2", if3.pc, 32'h22);
      chk("f3_flush_t2", {31'b0, if3.flush}, 32'h1);
      chk("f3_redirect_t2", {31'b0, if3.redirect}, 32'h0);
      step();
      chk("f3_pc_end", if3.pc, 32'h23);
      chk("f3_flush_end", {31'b0, if3.flush}, 32'h0);
      chk("f3_redirect_back", {31'b0, if3.redirect}, 32'h1);
      if3.pc_sel = 2'b00;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Parametrised program-counter and branch-target unit; successor to the combinational branch adder (BrA = PC_2 + seIM).
- Holds the PC register and a one-stage pipelined PC+1 (pc_2).
- Computes the branch target from a sign-extended immediate and selects the next PC: sequential, taken branch, or jump register.
- Squashes wrong-path fetches for a programmable number of cycles after a redirect; sits between instruction memory addressing and the decode stage.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- IM_W, 15, immediate width; sign-extended to ADDR_W.
- RESET_PC, 0, PC value loaded on reset.
- FLUSH_CYCLES, 1, squash cycles after an accepted redirect; legal 1..3.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all state this cycle.
- pc_sel  in  2  00 sequential, 01 conditional branch, 10 jump register, 11 hold PC.
- br_cond  in  1  branch condition (e.g. zero flag), used only when pc_sel=01.
- imm  in  IM_W  branch offset, two's complement.
- jr_addr  in  ADDR_W  jump-register target.
- pc  out  ADDR_W  current fetch address (registered).
- pc_2  out  ADDR_W  registered pc+1 of the previous fetch.
- bra  out  ADDR_W  combinational pc_2 + sext(imm).
- redirect  out  1  combinational; high when a redirect is accepted this cycle.
- flush  out  1  registered squash indication to decode.
- bra_ovf  out  1  branch-target wrap flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0) sets pc=RESET_PC, pc_2=0, flush=0, bra_ovf=0 and state=RUN. Reset mid-flush aborts the flush immediately. bra then equals sext(imm) from pc_2=0.
- Arithmetic is modulo 2^ADDR_W. sext replicates imm[IM_W-1]. pc+1 at all-ones wraps to 0.
- bra is combinational and always valid, independent of pc_sel.
- Registers update only when stall=0:
  - pc_2 <= pc+1.
  - pc <= next_pc.
- next_pc priority in RUN:
  - pc_sel=10: jr_addr.
  - pc_sel=01 and br_cond=1: bra.
  - pc_sel=11: pc (hold).
  - Otherwise: pc+1.
- redirect=1 when state=RUN, stall=0, and either pc_sel=10 or (pc_sel=01 and br_cond=1). Jump with pc_sel=10 and br_cond=1 is a jump; br_cond is ignored.
- State machine:
  - RUN: on redirect go to FLUSH; counter <= FLUSH_CYCLES-1; flush <= 1.
  - FLUSH: flush held 1. pc advances sequentially (pc+1) and pc_sel is ignored, so no redirect is accepted because the requesting instruction is being squashed. When counter=0, go to RUN and set flush <= 0; otherwise decrement the counter.
- flush goes high the cycle after the redirect edge and stays high exactly FLUSH_CYCLES non-stalled cycles.
- Stall in FLUSH freezes the counter, pc, pc_2 and flush.
- Stall in RUN:
  - redirect is 0.
  - The request is not latched; decode re-presents it after the stall.
- Latency:
  - pc_sel/imm to pc update: 1 clock.
  - Redirect to first correct-path decode: FLUSH_CYCLES+1 clocks.

Optional Feature:
- Macro: PC_BRANCH_OVF_EN.
- Defined: on each cycle where redirect=1 and pc_sel=01, bra_ovf <= 1 if the unsigned add wrapped in the wrong direction. That is: imm non-negative and carry-out=1, or imm negative and carry-out=0. Otherwise bra_ovf <= 0. Registered, one-cycle pulse; held during stall.
- Undefined: bra_ovf tied 0 and no overflow logic is synthesised. Wrap-around of the target is still performed.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> pc=0, pc_2=0, flush=0 immediately. Release with pc_sel=00 -> pc=0,1,2,3 and pc_2=0,1,2,3 on successive clocks (pc_2 shows the previous pc+1; first value is the reset 0).
- Backward branch: run to pc=11 (pc_2=12 next cycle); set pc_sel=01, br_cond=1, imm=15'h7FF4 -> bra=0, redirect=1, next pc=0. flush=1 for FLUSH_CYCLES=1 cycle, then pc=1,2.
- Not taken / jump: pc_sel=01, br_cond=0 -> pc+1, redirect=0. pc_sel=10, jr_addr=32'h0000_0100 -> pc=0x100, flush pulse.
- Flush window with FLUSH_CYCLES=3: taken branch, then pc_sel=10 presented during the flush -> ignored, pc sequential from target. flush high exactly 3 cycles; stall=1 inside the window extends it by the stall length with pc frozen.
- Wrap: pc_2=32'hFFFF_FFFE, imm=+3 -> bra=1. With PC_BRANCH_OVF_EN, bra_ovf=1 for one cycle after a taken branch. Without the macro, bra_ovf stays 0. pc=32'hFFFF_FFFF sequential -> pc=0.
- Stall in RUN: stall=1 with pc_sel=01, br_cond=1 -> pc and pc_2 unchanged, redirect=0, flush=0. Deassert stall with the same inputs -> branch taken next clock.
